// File: rtl/snake_pkg.sv
// Shared types and constants for the snake LCD drawing path: object codes,
// RGB565 colours, LCD opcodes and the cell-draw FSM states.
package snake_pkg;

    typedef enum logic [2:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_BODY   = 3'd1,
        OBJ_HEAD   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_code_t;

    typedef enum logic [2:0] {
        IDLE,
        CASET_C,
        CASET_D,
        PASET_C,
        PASET_D,
        RAMWR_C,
        PIXELS
    } draw_state_t;

    localparam logic [15:0] RGB_EMPTY  = 16'h0000;
    localparam logic [15:0] RGB_BODY   = 16'h07E0;
    localparam logic [15:0] RGB_HEAD   = 16'hFFE0;
    localparam logic [15:0] RGB_APPLE  = 16'hF800;
    localparam logic [15:0] RGB_BORDER = 16'h001F;

    localparam logic [7:0] LCD_CASET = 8'h2A;
    localparam logic [7:0] LCD_PASET = 8'h2B;
    localparam logic [7:0] LCD_RAMWR = 8'h2C;

    // Unassigned codes 101..111 fall through to the background colour.
    function automatic logic [15:0] obj_colour(input obj_code_t code);
        case (code)
            OBJ_BODY:   return RGB_BODY;
            OBJ_HEAD:   return RGB_HEAD;
            OBJ_APPLE:  return RGB_APPLE;
            OBJ_BORDER: return RGB_BORDER;
            default:    return RGB_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/cell_draw_ctrl_if.sv
// Byte-wide valid/ready link from the cell drawer to the LCD bus writer.
interface cell_draw_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_dc;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_dc, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_dc, input wr_data, output wr_ready);
endinterface

// File: rtl/cell_draw_ctrl.sv
// Turns each changed grid cell into an LCD window + RAM write + colour fill byte
// stream, holding frame_tracker off while the cell is being drawn.
module cell_draw_ctrl
    import snake_pkg::*;
#(
    parameter int          CELL_PX  = 10,
    parameter logic [15:0] X_OFFSET = 16'd0,
    parameter logic [15:0] Y_OFFSET = 16'd0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [3:0]       x,
    input  logic [3:0]       y,
    input  logic [2:0]       obj_code,
    input  logic             diff,
    output logic             tracker_en,
    output logic             busy,
    output logic             cell_done,
    cell_draw_ctrl_if.master wr
);

    localparam int PIX_N = CELL_PX * CELL_PX;
    localparam int PIX_W = $clog2(PIX_N + 1);

    draw_state_t      state_q, state_d;
    logic [1:0]       idx_q;
    logic [PIX_W-1:0] pix_q;
    logic             lo_q;
    logic [3:0]       x_q, y_q;
    logic [2:0]       obj_q;
    logic             accept, param_last, last_byte;
    logic [15:0]      xs, xe, ys, ye, colour;

    function automatic logic [7:0] param_byte(input logic [15:0] s, input logic [15:0] e,
                                              input logic [1:0] i);
        case (i)
            2'd0:    return s[15:8];
            2'd1:    return s[7:0];
            2'd2:    return e[15:8];
            default: return e[7:0];
        endcase
    endfunction

    assign busy       = (state_q != IDLE);
    assign tracker_en = ~busy;
    assign accept     = busy & wr.wr_ready;
    assign param_last = (idx_q == 2'd3);
    assign last_byte  = (state_q == PIXELS) && lo_q && (pix_q == PIX_W'(PIX_N - 1));

    // Window corners wrap mod 2^16 by construction of the 16-bit arithmetic.
    assign xs     = X_OFFSET + 16'(x_q) * 16'(CELL_PX);
    assign xe     = xs + 16'(CELL_PX - 1);
    assign ys     = Y_OFFSET + 16'(y_q) * 16'(CELL_PX);
    assign ye     = ys + 16'(CELL_PX - 1);
    assign colour = obj_colour(obj_code_t'(obj_q));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (diff) state_d = CASET_C;
            CASET_C: if (accept) state_d = CASET_D;
            CASET_D: if (accept && param_last) state_d = PASET_C;
            PASET_C: if (accept) state_d = PASET_D;
            PASET_D: if (accept && param_last) state_d = RAMWR_C;
            RAMWR_C: if (accept) state_d = PIXELS;
            PIXELS:  if (accept && last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte presented is a pure function of state and counters, so it cannot move
    // until the writer accepts it.
    always_comb begin
        wr.wr_valid = busy;
        wr.wr_dc    = 1'b0;
        wr.wr_data  = 8'h00;
        case (state_q)
            CASET_C: wr.wr_data = LCD_CASET;
            CASET_D: begin
                wr.wr_dc   = 1'b1;
                wr.wr_data = param_byte(xs, xe, idx_q);
            end
            PASET_C: wr.wr_data = LCD_PASET;
            PASET_D: begin
                wr.wr_dc   = 1'b1;
                wr.wr_data = param_byte(ys, ye, idx_q);
            end
            RAMWR_C: wr.wr_data = LCD_RAMWR;
            PIXELS: begin
                wr.wr_dc   = 1'b1;
                wr.wr_data = lo_q ? colour[7:0] : colour[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q     <= 2'd0;
            pix_q     <= '0;
            lo_q      <= 1'b0;
            cell_done <= 1'b0;
        end else begin
            cell_done <= accept & last_byte;
            if (accept) begin
                case (state_q)
                    CASET_D, PASET_D: idx_q <= idx_q + 2'd1;
                    PIXELS: begin
                        lo_q <= ~lo_q;
                        if (lo_q) pix_q <= last_byte ? '0 : pix_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && diff) begin
            x_q   <= x;
            y_q   <= y;
            obj_q <= obj_code;
        end
    end

endmodule
